// File: rtl/display_scan_mux.sv
// Scans NUM_DIGITS buffered values onto one shared decoder input with active-low anodes.
// Inputs are captured once per frame, and each slot has PWM dimming and a dark first cycle.
module display_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int VAL_W       = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIM_BITS    = 3,
  localparam int IDX_W      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_DIGITS*VAL_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       blank,
  input  logic [DIM_BITS-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [VAL_W-1:0]            val_out,
  output logic [IDX_W-1:0]            digit_idx,
  output logic                        frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  // Duty compare width: (2^DIM_BITS)*REFRESH_DIV must fit without truncation.
  localparam int CMP_W = $clog2(REFRESH_DIV + 1) + DIM_BITS + 1;

  logic [CNT_W-1:0]            slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS*VAL_W-1:0] val_buf_q, val_buf_d;
  logic [NUM_DIGITS-1:0]       blank_buf_q, blank_buf_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [VAL_W-1:0]            val_out_q, val_out_d;
  logic                        frame_tick_q, frame_tick_d;

  logic [VAL_W-1:0] buf_vals [NUM_DIGITS];
  logic [CMP_W-1:0] duty_lhs, duty_rhs;
  logic             capture, duty_ok, lit;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
    assign buf_vals[gi] = val_buf_q[gi*VAL_W +: VAL_W];
  end

  assign duty_lhs = CMP_W'(slot_cnt_q) << DIM_BITS;
  assign duty_rhs = (CMP_W'(brightness) + CMP_W'(1)) * CMP_W'(REFRESH_DIV);
  assign duty_ok  = (duty_lhs <= duty_rhs);

  always_comb begin
    capture      = en && (slot_cnt_q == '0) && (idx_q == '0);
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    val_buf_d    = val_buf_q;
    blank_buf_d  = blank_buf_q;
    if (en) begin
      if (slot_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        slot_cnt_d = '0;
        idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
      if (capture) begin
        val_buf_d   = digits_in;
        blank_buf_d = blank;
      end
    end

    // Slot count 0 stays dark so the previous digit's segments never bleed into the next anode.
    lit = en && (slot_cnt_q != '0) && !blank_buf_q[idx_q] && duty_ok;

    an_d      = '1;
    val_out_d = '0;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      val_out_d   = buf_vals[idx_q];
    end
    frame_tick_d = capture;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      val_buf_q    <= '0;
      blank_buf_q  <= '1;
      an_q         <= '1;
      val_out_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      val_buf_q    <= val_buf_d;
      blank_buf_q  <= blank_buf_d;
      an_q         <= an_d;
      val_out_q    <= val_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign val_out    = val_out_q;
  assign digit_idx  = idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Randomised bench for display_scan_mux, checked against a position-counting frame model.
module tb_display_scan_mux;

  localparam int ND  = 4;
  localparam int VW  = 4;
  localparam int DIV = 8;
  localparam int DB  = 3;
  localparam int FRAME = DIV * ND;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           en = 1'b0;
  logic [ND*VW-1:0] digits_in = '0;
  logic [ND-1:0]  blank = '0;
  logic [DB-1:0]  brightness = '0;
  logic [ND-1:0]  an;
  logic [VW-1:0]  val_out;
  logic [1:0]     digit_idx;
  logic           frame_tick;

  int n_vec = 0;
  int n_err = 0;

  // Model: m_pos counts enabled cycles since reset; slot and digit fall out of it arithmetically.
  int             m_pos = 0;
  logic [ND*VW-1:0] m_vbuf = '0;
  logic [ND-1:0]  m_bbuf = '1;

  display_scan_mux #(
    .NUM_DIGITS(ND), .VAL_W(VW), .REFRESH_DIV(DIV), .DIM_BITS(DB)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .digits_in(digits_in), .blank(blank),
    .brightness(brightness), .an(an), .val_out(val_out), .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos  = 0;
    m_vbuf = '0;
    m_bbuf = '1;
  endtask

  // One clock: predict outputs from model state and current inputs, clock, compare.
  task automatic step(input string tag);
    int slot, dig;
    bit lit, e_ft;
    logic [ND-1:0] e_an;
    logic [VW-1:0] e_val;
    logic [1:0]    e_idx;
    slot  = m_pos % DIV;
    dig   = (m_pos / DIV) % ND;
    lit   = en && slot != 0 && !m_bbuf[dig] &&
            (slot * (1 << DB) <= (int'(brightness) + 1) * DIV);
    e_an  = '1;
    e_val = '0;
    if (lit) begin
      e_an[dig] = 1'b0;
      e_val     = m_vbuf[dig*VW +: VW];
    end
    e_ft = en && (m_pos % FRAME == 0);
    if (en) begin
      if (e_ft) begin
        m_vbuf = digits_in;
        m_bbuf = blank;
      end
      m_pos++;
    end
    e_idx = 2'((m_pos / DIV) % ND);
    @(posedge clk);
    #1;
    n_vec++;
    if (an !== e_an) begin
      n_err++;
      $display("FAIL %s an: got %b expected %b (pos %0d)", tag, an, e_an, m_pos);
    end
    n_vec++;
    if (val_out !== e_val) begin
      n_err++;
      $display("FAIL %s val_out: got %h expected %h (pos %0d)", tag, val_out, e_val, m_pos);
    end
    n_vec++;
    if (frame_tick !== e_ft) begin
      n_err++;
      $display("FAIL %s frame_tick: got %b expected %b (pos %0d)", tag, frame_tick, e_ft, m_pos);
    end
    n_vec++;
    if (digit_idx !== e_idx) begin
      n_err++;
      $display("FAIL %s digit_idx: got %0d expected %0d (pos %0d)", tag, digit_idx, e_idx, m_pos);
    end
    n_vec++;
    if ($countones(~an) > 1) begin
      n_err++;
      $display("FAIL %s onehot_anode: got %b expected at most one low bit", tag, an);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  // Advance until the model sits at the given position within a frame (before the next edge).
  task automatic run_until(input string tag, input int frame_pos);
    for (int k = 0; k < 2 * FRAME && (m_pos % FRAME) != frame_pos; k++) step(tag);
    n_vec++;
    if ((m_pos % FRAME) != frame_pos) begin
      n_err++;
      $display("FAIL %s reach_pos: got %0d expected %0d", tag, m_pos % FRAME, frame_pos);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (an !== 4'hF || val_out !== 4'h0 || frame_tick !== 1'b0 || digit_idx !== 2'd0) begin
      n_err++;
      $display("FAIL %s: got an=%b val=%h ft=%b idx=%0d expected an=1111 val=0 ft=0 idx=0",
               tag, an, val_out, frame_tick, digit_idx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en         = 1'($urandom);
      digits_in  = 16'($urandom);
      blank      = 4'($urandom);
      brightness = 3'($urandom);
      @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");
    end
    digits_in  = 16'h1234;
    blank      = 4'h0;
    brightness = 3'd7;
    en         = 1'b1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_scan();
    run("scan", 2 * FRAME);
  endtask

  task automatic test_blank();
    blank = 4'b0100;
    run("blank", 2 * FRAME + 4);
    blank = 4'b0000;
    run("unblank", FRAME);
  endtask

  task automatic test_brightness();
    brightness = 3'd3;
    run("bright3", FRAME + 8);
    brightness = 3'd0;
    run("bright0", FRAME);
    for (int k = 0; k < 2 * FRAME; k++) begin
      brightness = 3'($urandom);
      step("bright_rand");
    end
    brightness = 3'd7;
  endtask

  task automatic test_antitear();
    digits_in = 16'h1234;
    run_until("tear_sync", 0);
    run("tear_load", FRAME);
    run_until("tear_sync2", 2 * DIV);
    digits_in = 16'hABCD;
    run("antitear", 2 * FRAME);
  endtask

  task automatic test_enable();
    run_until("en_sync", DIV + 5);
    en = 1'b0;
    run("en_low", 10);
    en = 1'b1;
    run("en_resume", FRAME + 4);
    for (int k = 0; k < 3 * FRAME; k++) begin
      en = ($urandom_range(0, 3) != 0);
      step("en_rand");
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    run_until("rst_sync", 2 * DIV + 3);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset_immediate");
    @(posedge clk);
    #1;
    check_reset_outputs("async_reset_clocked");
    model_reset();
    reset = 1'b1;
    run("after_reset", FRAME + 8);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank = 4'($urandom);
      if ($urandom_range(0, 7) == 0) brightness = 3'($urandom);
      en = ($urandom_range(0, 7) != 0);
      step("random");
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_brightness();
    test_antitear();
    test_enable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
